// File: rtl/cdce_iic_pkg.sv
// Shared definitions for the CDCE I2C waveform encoder: slot levels, FSM
// encoding and the write-sequence builder.
package cdce_iic_pkg;

    // Slot levels packed as {scl, sda}
    localparam logic [1:0] SLOT_START     = 2'b10;
    localparam logic [1:0] SLOT_ACK       = 2'b01;
    localparam logic [1:0] SLOT_STOP_PREP = 2'b00;
    localparam logic [1:0] SLOT_STOP      = 2'b11;
    localparam logic [1:0] SLOT_IDLE      = 2'b11;

    localparam logic [31:0] IDLE_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_W0,
        ST_W1,
        ST_DLY
    } state_t;

    // Returns {word0, word1}; each word is {scl[15:0], sda[15:0]}, slot 0 at the MSB.
    function automatic logic [63:0] build_write_words(
        input logic [6:0] dev,
        input logic [7:0] reg_addr,
        input logic [7:0] data
    );
        logic [31:0] scl;
        logic [31:0] sda;
        scl = {SLOT_START[1], 8'h00, SLOT_ACK[1], 8'h00, SLOT_ACK[1], 8'h00, SLOT_ACK[1],
               SLOT_STOP_PREP[1], SLOT_STOP[1], SLOT_IDLE[1], SLOT_IDLE[1]};
        sda = {SLOT_START[0], dev, 1'b0, SLOT_ACK[0], reg_addr, SLOT_ACK[0], data, SLOT_ACK[0],
               SLOT_STOP_PREP[0], SLOT_STOP[0], SLOT_IDLE[0], SLOT_IDLE[0]};
        return {scl[31:16], sda[31:16], scl[15:0], sda[15:0]};
    endfunction

endpackage

// File: rtl/cdce_iic_encoder.sv
// Streams CDCE register-write and delay commands into 32-bit I2C waveform
// words for the downstream waveform player.
module cdce_iic_encoder
    import cdce_iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h65
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy
);

    state_t      state_q, state_n;
    logic [63:0] words_q, words_n;
    logic [15:0] cnt_q, cnt_n;
    logic [31:0] tdata_q, tdata_n;
    logic        tvalid_q, tvalid_n;

    logic        s_hs;
    logic        m_hs;
    logic [6:0]  dev_sel;
    logic [63:0] write_words;

    // Ready is gated by reset so no command is taken while aresetn is low
    assign s_axis_tready = aresetn && (state_q == ST_IDLE);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = tvalid_q && m_axis_tready;
    assign dev_sel       = (s_axis_tdata[22:16] == 7'd0) ? DEV_ADDR : s_axis_tdata[22:16];
    assign write_words   = build_write_words(dev_sel, s_axis_tdata[15:8], s_axis_tdata[7:0]);

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != ST_IDLE);

    always_comb begin
        state_n  = state_q;
        words_n  = words_q;
        cnt_n    = cnt_q;
        tdata_n  = tdata_q;
        tvalid_n = tvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (s_hs) begin
                    if (!s_axis_tdata[31]) begin
                        words_n  = write_words;
                        tdata_n  = write_words[63:32];
                        tvalid_n = 1'b1;
                        state_n  = ST_W0;
                    end else if (s_axis_tdata[15:0] != 16'd0) begin
                        cnt_n    = s_axis_tdata[15:0];
                        tdata_n  = IDLE_WORD;
                        tvalid_n = 1'b1;
                        state_n  = ST_DLY;
                    end
                end
            end
            ST_W0: begin
                if (m_hs) begin
                    tdata_n = words_q[31:0];
                    state_n = ST_W1;
                end
            end
            ST_W1: begin
                if (m_hs) begin
                    tdata_n  = IDLE_WORD;
                    tvalid_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            ST_DLY: begin
                if (m_hs) begin
                    cnt_n = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        tvalid_n = 1'b0;
                        state_n  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n  = ST_IDLE;
                tdata_n  = IDLE_WORD;
                tvalid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            words_q  <= '0;
            cnt_q    <= '0;
            tdata_q  <= IDLE_WORD;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            words_q  <= words_n;
            cnt_q    <= cnt_n;
            tdata_q  <= tdata_n;
            tvalid_q <= tvalid_n;
        end
    end

endmodule

// File: tb/tb_cdce_iic_encoder.sv
// Directed and randomized-backpressure checks for cdce_iic_encoder.
module tb_cdce_iic_encoder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        busy;

    int total = 0;
    int passed = 0;

    logic [31:0] exp_q[$];
    logic        stop = 1'b0;
    logic        drv_done = 1'b0;

    always #5 aclk = ~aclk;

    cdce_iic_encoder #(.DEV_ADDR(7'h65)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Independent slot-by-slot reference of the I2C write sequence
    function automatic logic [63:0] ref_words(input logic [31:0] cmd);
        logic [23:0] bits;
        logic [6:0]  dev;
        logic [63:0] w;
        logic        c, d;
        int unsigned wi, bi;
        dev  = (cmd[22:16] == 7'd0) ? 7'h65 : cmd[22:16];
        bits = {dev, 1'b0, cmd[15:8], cmd[7:0]};
        w    = '0;
        for (int k = 0; k < 32; k++) begin
            c = 1'b0;
            if (k == 0)               begin c = 1'b1; d = 1'b0; end
            else if (k <= 8)          d = bits[24 - k];
            else if (k == 9)          d = 1'b1;
            else if (k <= 17)         d = bits[25 - k];
            else if (k == 18)         d = 1'b1;
            else if (k <= 26)         d = bits[26 - k];
            else if (k == 27)         d = 1'b1;
            else if (k == 28)         d = 1'b0;
            else                      begin c = 1'b1; d = 1'b1; end
            wi = 32'(k) / 16;
            bi = 15 - (32'(k) % 16);
            w[63 - 32*wi - (15 - bi)] = c;
            w[47 - 32*wi - (15 - bi)] = d;
        end
        return w;
    endfunction

    initial begin
        logic [63:0] rw;
        logic [31:0] cmd;
        int          cyc;
        logic        acc;

        // Reset state
        step(); step();
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", m_tdata, 32'hFFFF_FFFF);
        chk("rst_busy", 32'(busy), 0);
        aresetn = 1'b1;
        step();
        chk("post_rst_s_tready", 32'(s_tready), 1);

        // Write with explicit address 0x65
        s_tdata = 32'h0065_05AA; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        chk("wr_w0_valid", 32'(m_tvalid), 1);
        chk("wr_w0_data", m_tdata, 32'h8000_6541);
        chk("wr_w0_s_tready", 32'(s_tready), 0);
        chk("wr_w0_busy", 32'(busy), 1);
        step();
        chk("wr_w1_valid", 32'(m_tvalid), 1);
        chk("wr_w1_data", m_tdata, 32'h0007_7557);
        step();
        chk("wr_end_valid", 32'(m_tvalid), 0);
        chk("wr_end_s_tready", 32'(s_tready), 1);

        // Address field 0 selects DEV_ADDR
        s_tdata = 32'h0000_05AA; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        chk("def_w0_data", m_tdata, 32'h8000_6541);
        step();
        chk("def_w1_data", m_tdata, 32'h0007_7557);
        step();
        chk("def_end_valid", 32'(m_tvalid), 0);

        // Delay of three idle words
        s_tdata = 32'h8000_0003; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dly3_valid_%0d", i), 32'(m_tvalid), 1);
            chk($sformatf("dly3_data_%0d", i), m_tdata, 32'hFFFF_FFFF);
            chk($sformatf("dly3_s_tready_%0d", i), 32'(s_tready), 0);
            step();
        end
        chk("dly3_end_valid", 32'(m_tvalid), 0);
        chk("dly3_end_s_tready", 32'(s_tready), 1);

        // Delay of zero consumes the command silently
        s_tdata = 32'h8000_0000; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        chk("dly0_valid", 32'(m_tvalid), 0);
        chk("dly0_s_tready", 32'(s_tready), 1);
        chk("dly0_busy", 32'(busy), 0);

        // Reset while presenting word 1
        s_tdata = 32'h0065_05AA; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        step();
        chk("rstw1_pre_data", m_tdata, 32'h0007_7557);
        aresetn = 1'b0;
        step();
        chk("rstw1_valid", 32'(m_tvalid), 0);
        chk("rstw1_data", m_tdata, 32'hFFFF_FFFF);
        chk("rstw1_busy", 32'(busy), 0);
        aresetn = 1'b1;
        cmd = 32'h0012_3C0F;
        rw = ref_words(cmd);
        s_tdata = cmd; s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        chk("after_rst_w0", m_tdata, rw[63:32]);
        step();
        chk("after_rst_w1", m_tdata, rw[31:0]);
        step();
        chk("after_rst_end", 32'(m_tvalid), 0);

        // Back-to-back writes: second accepted three cycles after the first
        s_tdata = 32'h0065_05AA; s_tvalid = 1'b1;
        step();
        cmd = 32'h0033_7E81;
        rw = ref_words(cmd);
        s_tdata = cmd;
        chk("b2b_t1_s_tready", 32'(s_tready), 0);
        step();
        chk("b2b_t2_s_tready", 32'(s_tready), 0);
        step();
        chk("b2b_t3_s_tready", 32'(s_tready), 1);
        step();
        s_tvalid = 1'b0;
        chk("b2b_second_w0", m_tdata, rw[63:32]);
        chk("b2b_second_valid", 32'(m_tvalid), 1);
        step();
        chk("b2b_second_w1", m_tdata, rw[31:0]);
        step();

        // 100 mixed commands under random backpressure
        fork
            begin : driver
                for (int i = 0; i < 100; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        cmd = {1'b1, 15'd0, 16'($urandom_range(0, 4))};
                    else
                        cmd = {1'b0, 8'($urandom),
                               ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom),
                               16'($urandom)};
                    s_tdata = cmd; s_tvalid = 1'b1;
                    cyc = 0;
                    acc = 1'b0;
                    while (!acc && cyc < 200) begin
                        @(negedge aclk);
                        acc = s_tready;
                        if (acc) begin
                            if (cmd[31]) begin
                                for (int n = 0; n < int'(cmd[15:0]); n++) exp_q.push_back(32'hFFFF_FFFF);
                            end else begin
                                rw = ref_words(cmd);
                                exp_q.push_back(rw[63:32]);
                                exp_q.push_back(rw[31:0]);
                            end
                        end
                        step();
                        cyc++;
                    end
                    if (!acc) chk("rand_accept_timeout", 32'(acc), 1);
                    s_tvalid = 1'b0;
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
                end
                cyc = 0;
                while ((exp_q.size() != 0 || busy) && cyc < 1000) begin
                    step();
                    cyc++;
                end
                chk("rand_drain", 32'(exp_q.size()), 0);
                stop = 1'b1;
            end
            begin : readiness
                while (!stop) begin
                    step();
                    m_tready = ($urandom_range(0, 2) != 0);
                end
                m_tready = 1'b1;
            end
            begin : monitor
                logic        stalled;
                logic [31:0] held;
                stalled = 1'b0;
                held    = '0;
                while (!stop) begin
                    @(negedge aclk);
                    if (stalled) begin
                        chk("stall_valid", 32'(m_tvalid), 1);
                        chk("stall_data", m_tdata, held);
                    end
                    stalled = 1'b0;
                    if (m_tvalid) begin
                        if (m_tready) begin
                            chk("rand_expected_avail", 32'(exp_q.size() > 0), 1);
                            if (exp_q.size() > 0) chk("rand_word", m_tdata, exp_q.pop_front());
                        end else begin
                            stalled = 1'b1;
                            held    = m_tdata;
                        end
                    end
                end
            end
        join

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdce_iic_encoder.md
# cdce_iic_encoder

Streaming encoder that turns register-write commands for the CDCE clock chip into 32-bit I2C waveform words, one bus slot per bit pair. It sits directly upstream of the I2C waveform player. Each output word carries 16 SCL levels in bits [31:16] and 16 SDA levels in bits [15:0], consumed MSB first. Configuration sequences can therefore come from software or a FIFO instead of a fixed ROM image.

## Interface
Parameters:
- DEV_ADDR, 7'h65, default 7-bit device address, used when the command address field is zero.

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset; synchronous, active-low
- s_axis_tdata  input  32  command word
- s_axis_tvalid  input  1  command valid
- s_axis_tready  output  1  command accepted when tvalid & tready
- m_axis_tdata  output  32  waveform word {scl[15:0], sda[15:0]}
- m_axis_tvalid  output  1  waveform word valid
- m_axis_tready  input  1  downstream ready
- busy  output  1  high in any state other than IDLE

## Operation
Command format:
- bit31 = 0: write command. Fields: [22:16] device address (0 selects DEV_ADDR), [15:8] register, [7:0] data. Bits [30:23] are ignored.
- bit31 = 1: delay command. [15:0] = N. Emits N idle words 0xFFFFFFFF. N = 0 emits nothing; the command is consumed with no output.

Slot encoding (per-slot pair is scl, sda):
- start = (1,0)
- data bit b = (0,b)
- ACK release = (0,1)
- stop prepare = (0,0)
- stop = (1,1)
- idle = (1,1)

Write sequence, 32 slots, output as 2 words:
- s0: start
- s1–s8: address[6:0] then W = 0
- s9: ACK
- s10–s17: register, MSB first
- s18: ACK
- s19–s26: data, MSB first
- s27: ACK
- s28: stop prepare
- s29: stop
- s30–s31: idle
- Slot k maps to word k/16, bit 15-(k%16), in both halves.

State machine:
- IDLE: s_axis_tready = 1. On accept:
  - write command → W0.
  - delay command with N > 0 → DLY, counter = N.
  - delay command with N = 0 → stays in IDLE.
- W0: presents word 0. On m_axis handshake → W1.
- W1: presents word 1. On m_axis handshake → IDLE.
- DLY: presents 0xFFFFFFFF. On each handshake the counter decrements; the handshake at counter = 1 → IDLE.

Outputs are registered:
- m_axis_tdata/tvalid stay stable while tvalid = 1 and tready = 0.
- Both words are precomputed at accept into a 64-bit register.

## Timing
- Reset values: s_axis_tready = 0 during reset and 1 in the first cycle after; m_axis_tvalid = 0; m_axis_tdata = 0xFFFFFFFF; busy = 0; state IDLE; delay counter = 0.
- Latency: command accepted at edge t → m_axis_tvalid = 1 after edge t (first word visible in cycle t+1).
- Throughput with m_axis_tready held high:
  - write command: 3 cycles per command (W0, W1, IDLE).
  - delay command: N+1 cycles.
- s_axis_tready is 0 in W0, W1 and DLY; commands are never buffered internally.
- Backpressure: the state only advances on an m_axis handshake. With tready low indefinitely the state holds and no word is lost or duplicated.
- Reset mid-operation discards the in-flight command. Any remaining words are not emitted.
- The 16-bit delay counter never wraps; the maximum of 65535 idle words is legal.

## Structure
- Package cdce_iic_pkg holds:
  - slot constants: SLOT_START, SLOT_ACK, SLOT_STOP_PREP, SLOT_STOP, SLOT_IDLE.
  - IDLE_WORD = 32'hFFFFFFFF.
  - state encoding.
  - function build_write_words(dev, reg, data) returning 64 bits.
- No sub-module. The encoder is one FSM plus a word register and the delay counter.

## Test plan
- Write command 0x00650 5AA, i.e. 32'h006505AA, with tready held high → words 0x80006541 then 0x00077557. tvalid is high for exactly 2 cycles and tready returns 1 on the third cycle.
- Write command with address field 0 (32'h000005AA), DEV_ADDR = 7'h65 → same two words as the previous scenario.
- Delay command 32'h80000003 → exactly three words of 0xFFFFFFFF. Delay command 32'h80000000 → no output, and tready stays high.
- Random m_axis_tready backpressure over 100 mixed commands → output matches the reference model word for word. tdata is stable across every stall.
- aresetn pulsed low while in W1 → tvalid is 0 the next cycle, word 1 is never emitted, and the next command encodes correctly.
- Back-to-back s_axis_tvalid with two write commands → second command accepted exactly 3 cycles after the first.
